// File: rtl/column_scheduler.sv
// column_scheduler: single-clock sequencer for the three falling-letter columns.
// Produces per-column fall-step enables, staggered column starts, score-driven speedup and respawn pulses.
`default_nettype none

module column_scheduler #(
   parameter int unsigned TICK_DIV     = 5000000,
   parameter int unsigned MIN_DIV      = 1000000,
   parameter int unsigned SPEEDUP_STEP = 250000,
   parameter int unsigned SCORE_SHIFT  = 3,
   parameter int unsigned START_DELAY2 = 30,
   parameter int unsigned START_DELAY3 = 60
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start,
   input  logic [7:0] score,
   input  logic [2:0] game_over,
   input  logic [2:0] correct,
   output logic [2:0] step_en,
   output logic [2:0] respawn,
   output logic       running,
   output logic [3:0] level,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RUN   = 2'd2,
      ST_OVER  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] tick_cnt_q, tick_cnt_d;
   logic [31:0] stag_q, stag_d;
   logic [2:0]  active_q, active_d;
   logic [2:0]  corr_prev_q;
   logic [2:0]  step_en_q, step_en_d;
   logic [2:0]  respawn_q, respawn_d;
   logic        running_q, running_d;
   logic [3:0]  level_q, level_d;

   logic [31:0] dec_w;
   logic [31:0] cur_div_w;
   logic [7:0]  shifted_w;
   logic [3:0]  target_w;
   logic        tick_w;
   logic        restart_w;

   // Clamp before subtracting so a large level can never underflow the period.
   always_comb begin
      dec_w = {28'd0, level_q} * SPEEDUP_STEP;
      if ((dec_w + MIN_DIV) >= TICK_DIV) begin
         cur_div_w = MIN_DIV;
      end else begin
         cur_div_w = TICK_DIV - dec_w;
      end
   end

   assign shifted_w = score >> SCORE_SHIFT;
   assign target_w  = (shifted_w > 8'd15) ? 4'd15 : shifted_w[3:0];
   assign tick_w    = (state_q == ST_RUN) && (tick_cnt_q >= (cur_div_w - 32'd1));
   assign restart_w = start && ((state_q == ST_IDLE) || (state_q == ST_OVER));

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      stag_d     = stag_q;
      active_d   = active_q;
      level_d    = level_q;
      step_en_d  = 3'b000;
      respawn_d  = 3'b000;
      running_d  = 1'b0;

      if (restart_w) begin
         state_d    = ST_CLEAR;
         respawn_d  = 3'b111;
         tick_cnt_d = 32'd0;
         stag_d     = 32'd0;
         level_d    = 4'd0;
         active_d   = 3'b001;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               state_d   = ST_RUN;
               running_d = 1'b1;
            end
            ST_RUN: begin
               if (|game_over) begin
                  state_d = ST_OVER;
               end else begin
                  running_d = 1'b1;
                  if (tick_w) begin
                     tick_cnt_d = 32'd0;
                     level_d    = target_w;
                     if (stag_q < START_DELAY3) begin
                        stag_d = stag_q + 32'd1;
                     end
                     if (stag_d == START_DELAY2) begin
                        active_d[1] = 1'b1;
                     end
                     if (stag_d == START_DELAY3) begin
                        active_d[2] = 1'b1;
                     end
                  end else begin
                     tick_cnt_d = tick_cnt_q + 32'd1;
                  end
                  respawn_d = correct & ~corr_prev_q;
                  // A respawn supersedes a coincident fall step on the same column.
                  step_en_d = {3{tick_w}} & active_q & ~respawn_d;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         tick_cnt_q  <= 32'd0;
         stag_q      <= 32'd0;
         active_q    <= 3'b000;
         corr_prev_q <= 3'b000;
         step_en_q   <= 3'b000;
         respawn_q   <= 3'b000;
         running_q   <= 1'b0;
         level_q     <= 4'd0;
      end else begin
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         stag_q      <= stag_d;
         active_q    <= active_d;
         corr_prev_q <= correct;
         step_en_q   <= step_en_d;
         respawn_q   <= respawn_d;
         running_q   <= running_d;
         level_q     <= level_d;
      end
   end

   assign step_en = step_en_q;
   assign respawn = respawn_q;
   assign running = running_q;
   assign level   = level_q;
   assign state   = state_q;

endmodule

`default_nettype wire

// File: tb/tb_column_scheduler.sv
// tb_column_scheduler: directed table-driven checks of the column scheduler with small parameters.
`default_nettype none

module tb_column_scheduler;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic [7:0] score;
   logic [2:0] game_over;
   logic [2:0] correct;
   logic [2:0] step_en;
   logic [2:0] respawn;
   logic       running;
   logic [3:0] level;
   logic [1:0] state;

   int tests = 0;
   int fails = 0;

   column_scheduler #(
      .TICK_DIV(10), .MIN_DIV(4), .SPEEDUP_STEP(2),
      .SCORE_SHIFT(3), .START_DELAY2(3), .START_DELAY3(6)
   ) dut (
      .clock(clk), .reset_n(reset_n), .start(start), .score(score),
      .game_over(game_over), .correct(correct), .step_en(step_en),
      .respawn(respawn), .running(running), .level(level), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       start;
      logic [7:0] score;
      logic [2:0] go;
      logic [2:0] corr;
      int         wait_n;
      logic [2:0] e_step;
      logic [2:0] e_resp;
      logic       e_run;
      logic [3:0] e_lvl;
      logic [1:0] e_st;
   } vec_t;

   vec_t tbl [0:18];

   function automatic vec_t mk(input int st, input int sc, input int go, input int co,
                               input int w, input int es, input int er, input int ern,
                               input int el, input int est);
      vec_t v;
      v.start  = st[0];
      v.score  = sc[7:0];
      v.go     = go[2:0];
      v.corr   = co[2:0];
      v.wait_n = w;
      v.e_step = es[2:0];
      v.e_resp = er[2:0];
      v.e_run  = ern[0];
      v.e_lvl  = el[3:0];
      v.e_st   = est[1:0];
      return v;
   endfunction

   task automatic chk(input string nm, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input int es, input int er, input int ern,
                          input int el, input int est);
      chk({tag, ".step_en"}, int'(step_en), es);
      chk({tag, ".respawn"}, int'(respawn), er);
      chk({tag, ".running"}, int'(running), ern);
      chk({tag, ".level"},   int'(level),   el);
      chk({tag, ".state"},   int'(state),   est);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Start, first steps with only column 0 active, stagger, then speedup.
      tbl[0]  = mk(1,   0, 0, 0,  1, 3'b000, 3'b111, 0,  0, 1);
      tbl[1]  = mk(0,   0, 0, 0,  1, 3'b000, 3'b000, 1,  0, 2);
      tbl[2]  = mk(0,   0, 0, 0,  9, 3'b000, 3'b000, 1,  0, 2);
      tbl[3]  = mk(0,   0, 0, 0,  1, 3'b001, 3'b000, 1,  0, 2);
      tbl[4]  = mk(0,   0, 0, 0,  1, 3'b000, 3'b000, 1,  0, 2);
      tbl[5]  = mk(0,   0, 0, 0,  9, 3'b001, 3'b000, 1,  0, 2);
      tbl[6]  = mk(0,   0, 0, 0, 10, 3'b001, 3'b000, 1,  0, 2);
      tbl[7]  = mk(0,   0, 0, 0, 10, 3'b011, 3'b000, 1,  0, 2);
      tbl[8]  = mk(0,   0, 0, 0, 10, 3'b011, 3'b000, 1,  0, 2);
      tbl[9]  = mk(0,   0, 0, 0, 10, 3'b011, 3'b000, 1,  0, 2);
      tbl[10] = mk(0,   0, 0, 0, 10, 3'b111, 3'b000, 1,  0, 2);
      tbl[11] = mk(0,   8, 0, 0, 10, 3'b111, 3'b000, 1,  1, 2);
      tbl[12] = mk(0,   8, 0, 0,  7, 3'b000, 3'b000, 1,  1, 2);
      tbl[13] = mk(0,   8, 0, 0,  1, 3'b111, 3'b000, 1,  1, 2);
      tbl[14] = mk(0,  40, 0, 0,  8, 3'b111, 3'b000, 1,  5, 2);
      tbl[15] = mk(0,  40, 0, 0,  3, 3'b000, 3'b000, 1,  5, 2);
      tbl[16] = mk(0,  40, 0, 0,  1, 3'b111, 3'b000, 1,  5, 2);
      tbl[17] = mk(0, 255, 0, 0,  4, 3'b111, 3'b000, 1, 15, 2);
      tbl[18] = mk(0, 255, 0, 0,  4, 3'b111, 3'b000, 1, 15, 2);

      reset_n   = 1'b0;
      start     = 1'b0;
      score     = 8'd0;
      game_over = 3'b000;
      correct   = 3'b000;
      cyc(2);
      chk_all("reset", 0, 0, 0, 0, 0);
      reset_n = 1'b1;

      for (int i = 0; i <= 18; i++) begin
         start     = tbl[i].start;
         score     = tbl[i].score;
         game_over = tbl[i].go;
         correct   = tbl[i].corr;
         cyc(tbl[i].wait_n);
         chk_all($sformatf("vec%0d", i), int'(tbl[i].e_step), int'(tbl[i].e_resp),
                 int'(tbl[i].e_run), int'(tbl[i].e_lvl), int'(tbl[i].e_st));
      end

      // Held correct: one respawn pulse only; period is 4 with counter at 0 here.
      correct = 3'b010;
      cyc(1); chk_all("corr_rise", 0, 3'b010, 1, 15, 2);
      cyc(1); chk_all("corr_held1", 0, 0, 1, 15, 2);
      cyc(1); chk_all("corr_held2", 0, 0, 1, 15, 2);
      cyc(1); chk_all("corr_held_step", 3'b111, 0, 1, 15, 2);
      cyc(1); chk_all("corr_held4", 0, 0, 1, 15, 2);
      correct = 3'b000;
      cyc(2);
      // Rising correct[1] on a tick cycle: respawn wins, column 1 step dropped.
      correct = 3'b010;
      cyc(1); chk_all("collide", 3'b101, 3'b010, 1, 15, 2);
      correct = 3'b000;

      // Game over together with correct: no respawn, then frozen.
      game_over = 3'b100;
      correct   = 3'b001;
      cyc(1); chk_all("go_enter", 0, 0, 0, 15, 3);
      game_over = 3'b000;
      correct   = 3'b000;
      cyc(5); chk_all("go_frozen", 0, 0, 0, 15, 3);
      start = 1'b1;
      cyc(1); chk_all("restart_clear", 0, 3'b111, 0, 0, 1);
      start = 1'b0;
      cyc(1); chk_all("restart_run", 0, 0, 1, 0, 2);
      cyc(9); chk_all("restart_pre", 0, 0, 1, 0, 2);
      cyc(1); chk_all("restart_step", 3'b001, 0, 1, 15, 2);

      // Asynchronous reset mid-run clears outputs at once; start is required to resume.
      cyc(3);
      reset_n = 1'b0;
      #1;
      chk_all("async_rst", 0, 0, 0, 0, 0);
      @(negedge clk);
      reset_n = 1'b1;
      cyc(12); chk_all("rst_idle", 0, 0, 0, 0, 0);
      start = 1'b1;
      cyc(1); chk_all("rst_start", 0, 3'b111, 0, 0, 1);
      start = 1'b0;
      cyc(1); chk_all("rst_run", 0, 0, 1, 0, 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/column_scheduler.md
Name: column_scheduler

Overview:
Sequences the three falling-letter Column datapaths from a single clock domain. It replaces per-column derived clocks with one-cycle step enables, staggers the start of columns 2 and 3, speeds up the fall rate as score rises, and issues respawn pulses on correct answers and at game start. It sits between Big_State_Machine (score) and the three Column instances.

Parameters:
TICK_DIV, 5000000, base clock cycles per fall step at level 0 (10 Hz at 50 MHz)
MIN_DIV, 1000000, floor on the cycles per fall step
SPEEDUP_STEP, 250000, cycles removed from the step period per level
SCORE_SHIFT, 3, level = score >> SCORE_SHIFT, saturated to 15
START_DELAY2, 30, fall ticks after game start before column 2 activates
START_DELAY3, 60, fall ticks after game start before column 3 activates

Ports:
clock  input  1  system clock (CLOCK_50)
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle start request
score  input  8  current score
game_over  input  3  per-column game-over flags
correct  input  3  per-column correct-answer flags
step_en  output  3  per-column one-cycle fall-step enable
respawn  output  3  per-column one-cycle clear/respawn pulse
running  output  1  high in RUN
level  output  4  current speed level
state  output  2  IDLE=0, CLEAR=1, RUN=2, OVER=3

Behaviour:
- Reset (async, reset_n=0): state=IDLE; step_en=0, respawn=0, running=0, level=0. Tick counter, stagger counter and active[2:0] are cleared. Reset applied mid-game aborts immediately; no pulse is emitted on release.
- All outputs are registered. An input sampled at edge N produces its effect at edge N+1.
- FSM:
  - IDLE: on start -> CLEAR.
  - CLEAR: lasts one cycle with respawn=3'b111. Clears the tick counter, stagger counter and level; sets active=3'b001. Goes to RUN. game_over and start are ignored in this state.
  - RUN: running=1. If game_over != 0, go to OVER on the next edge; that cycle's step_en and respawn are forced to 0. start is ignored.
  - OVER: step_en=0, respawn=0. Frozen until start -> CLEAR.
- Tick generator (RUN only):
  - A counter runs 0..cur_div-1. tick is high for one cycle when the count equals cur_div-1, then the counter wraps to 0.
  - cur_div = max(MIN_DIV, TICK_DIV - level*SPEEDUP_STEP), computed at 32-bit width with no underflow (clamp before subtracting).
- Level: target = min(15, score >> SCORE_SHIFT). level loads target only on a tick cycle, so the period never changes mid-step.
- Stagger:
  - The stagger counter increments on each tick and saturates at START_DELAY3.
  - active[1] sets on the tick where the post-increment count equals START_DELAY2. active[2] sets when it equals START_DELAY3.
  - Once set, active bits stay set until CLEAR.
- step_en[i] = tick & active[i] & (state==RUN), registered, so it appears one cycle after the tick.
- respawn[i] in RUN is a one-cycle pulse the cycle after a rising edge of correct[i] (edge-detected). A level held high gives one pulse only.
- Collision: if respawn[i] and step_en[i] would be high in the same cycle, respawn wins and that step is dropped.
- Simultaneous game_over and correct in RUN: game_over wins; no respawn is issued.
- Inactive columns never receive step_en. They do receive respawn from CLEAR.

Test Plan:
Use parameters TICK_DIV=10, MIN_DIV=4, SPEEDUP_STEP=2, SCORE_SHIFT=3, START_DELAY2=3, START_DELAY3=6.
1. Reset then start pulse -> one cycle CLEAR with respawn=111. Then RUN; step_en[0] pulses every 10 cycles; step_en[2:1] stay 0.
2. Stagger: keep running -> step_en[1] first pulses on the 4th step of column 0. step_en[2] first pulses on the 7th. From then on all three pulse in the same cycle.
3. Speed: score=8 -> after the next tick, level=1 and period=8. Score=40 -> level=5, period clamps to 4. Score=255 -> level=15, period stays 4.
4. correct=010 held for 5 cycles -> exactly one respawn=010 pulse, one cycle after the rise. If it coincides with a step_en[1] cycle, that step is absent.
5. game_over=100 during RUN -> OVER next cycle, step_en=0, running=0. Asserting correct and game_over together yields no respawn. A later start -> CLEAR (respawn=111), level=0, active=001.
6. Drop reset_n mid-RUN for 1 cycle -> all outputs 0 at once, state=IDLE. start is required to resume.
